freq_input_filter: RTL and testbench

//  Conditions a raw, asynchronous field input before it reaches the frequency counter.
//  - Synchronises the input and applies optional inversion.
//  - Rejects glitches shorter than FILTER_LEN clocks.
//  - Divides the clean edge stream by a run-time prescale.
//  - sig_div drives the counter's SIGNAL input. Edge and glitch counts are exported as status.

---
 rtl/freq_input_filter.sv | 68 ++++++
 tb/tb_freq_input_filter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/freq_input_filter.sv
// freq_input_filter: synchronises, deglitches and prescales a raw field input
// ahead of the frequency counter, exporting edge and glitch statistics.
module freq_input_filter #(
    parameter int FILTER_LEN = 8,
    parameter int PRESCALE_W = 8,
    parameter int GLITCH_W   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SIGNAL_IN,
    input  logic                  enable,
    input  logic                  invert,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sig_filt,
    output logic                  sig_div,
    output logic [31:0]           edge_count,
    output logic [GLITCH_W-1:0]   glitch_count
);
    localparam int SW = $clog2(FILTER_LEN + 1);
    localparam logic [SW-1:0] LAST = SW'(FILTER_LEN - 1);

    logic [1:0]            sync_q;
    logic                  filt_q, filt_d, div_q, div_d;
    logic [SW-1:0]         stab_q, stab_d;
    logic [PRESCALE_W-1:0] dcnt_q, dcnt_d;
    logic [31:0]           edge_q, edge_d;
    logic [GLITCH_W-1:0]   glitch_q, glitch_d;
    logic                  s, diff, accept, rise;

    // A level returning to sig_filt before acceptance is a rejected glitch.
    always_comb begin
        s        = sync_q[1] ^ invert;
        diff     = s != filt_q;
        accept   = enable && diff && stab_q == LAST;
        rise     = accept && s;
        filt_d   = accept ? s : filt_q;
        stab_d   = (!enable || !diff || accept) ? '0 : stab_q + 1'b1;
        glitch_d = (enable && !diff && stab_q != '0 && glitch_q != '1) ? glitch_q + 1'b1 : glitch_q;
        edge_d   = rise ? edge_q + 32'd1 : edge_q;
        div_d    = rise && dcnt_q >= prescale;
        dcnt_d   = (!enable || div_d) ? '0 : rise ? dcnt_q + 1'b1 : dcnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            filt_q   <= 1'b0;
            div_q    <= 1'b0;
            stab_q   <= '0;
            dcnt_q   <= '0;
            edge_q   <= '0;
            glitch_q <= '0;
        end else begin
            sync_q   <= {sync_q[0], SIGNAL_IN};
            filt_q   <= filt_d;
            div_q    <= div_d;
            stab_q   <= stab_d;
            dcnt_q   <= dcnt_d;
            edge_q   <= edge_d;
            glitch_q <= glitch_d;
        end
    end

    assign sig_filt     = filt_q;
    assign sig_div      = div_q;
    assign edge_count   = edge_q;
    assign glitch_count = glitch_q;
endmodule

// File: tb/tb_freq_input_filter.sv
// tb_freq_input_filter: directed and random stimulus against a run-length
// reference model; a narrow-glitch-counter instance exercises saturation.
module tb_freq_input_filter;
    localparam int FL = 8;

    logic        clk = 0, rst_n = 0, SIGNAL_IN = 0, enable = 0, invert = 0;
    logic [7:0]  prescale = 0;
    logic        sig_filt, sig_div, sf2, sd2;
    logic [31:0] edge_count, ec2;
    logic [15:0] glitch_count;
    logic [3:0]  gc2;
    int          total = 0, bad = 0, cyc = 0, n;
    int          ptimes[$];

    logic [1:0]  m_pipe;
    logic        m_filt, m_pulse;
    int          m_run, m_div, m_glitch;
    logic [31:0] m_edges, e0, sv_edge;
    logic [15:0] sv_glitch;
    logic        sv_filt;

    always #5 clk = ~clk;

    freq_input_filter #(.FILTER_LEN(FL), .PRESCALE_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .SIGNAL_IN(SIGNAL_IN), .enable(enable), .invert(invert),
        .prescale(prescale), .sig_filt(sig_filt), .sig_div(sig_div),
        .edge_count(edge_count), .glitch_count(glitch_count));

    freq_input_filter #(.FILTER_LEN(FL), .PRESCALE_W(8), .GLITCH_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .SIGNAL_IN(SIGNAL_IN), .enable(enable), .invert(invert),
        .prescale(prescale), .sig_filt(sf2), .sig_div(sd2),
        .edge_count(ec2), .glitch_count(gc2));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        m_pipe = 0; m_filt = 0; m_pulse = 0; m_run = 0; m_div = 0; m_glitch = 0; m_edges = 0;
    endtask

    // Model: the level seen after two clocks of delay must differ from the
    // accepted level for FL consecutive clocks; a shorter run is a glitch.
    task automatic mstep();
        logic s;
        s = m_pipe[1] ^ invert;
        m_pipe = {m_pipe[0], SIGNAL_IN};
        m_pulse = 0;
        if (!enable) begin
            m_run = 0; m_div = 0;
        end else if (s == m_filt) begin
            if (m_run > 0) m_glitch++;
            m_run = 0;
        end else begin
            m_run++;
            if (m_run == FL) begin
                m_filt = s; m_run = 0;
                if (s) begin
                    m_edges++;
                    if (m_div >= int'(prescale)) begin m_pulse = 1; m_div = 0; end
                    else m_div++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) mstep();
        @(negedge clk);
        cyc++;
        if (sig_div) ptimes.push_back(cyc);
        chk("sig_filt", 32'(sig_filt), 32'(m_filt));
        chk("sig_div", 32'(sig_div), 32'(m_pulse));
        chk("edge_count", edge_count, m_edges);
        chk("glitch_count", 32'(glitch_count), 32'(m_glitch > 65535 ? 65535 : m_glitch));
        chk("sat_filt", 32'(sf2), 32'(m_filt));
        chk("sat_div", 32'(sd2), 32'(m_pulse));
        chk("sat_edges", ec2, m_edges);
        chk("sat_glitch", 32'(gc2), 32'(m_glitch > 15 ? 15 : m_glitch));
    endtask

    task automatic hold(input logic lvl, input int k);
        SIGNAL_IN = lvl;
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic periods(input int k, input int half);
        for (int i = 0; i < k; i++) begin
            hold(1'b1, half);
            hold(1'b0, half);
        end
    endtask

    initial begin
        mreset();
        // Reset with a toggling input
        for (int i = 0; i < 6; i++) begin
            SIGNAL_IN = ~SIGNAL_IN;
            tick();
        end
        chk("rst_outputs", {sig_filt, sig_div, 14'd0, glitch_count}, 32'd0);
        chk("rst_edges", edge_count, 32'd0);
        SIGNAL_IN = 0; enable = 1; prescale = 0;
        rst_n = 1;
        ptimes.delete();
        hold(1'b0, 20);
        chk("release_no_pulse", ptimes.size(), 0);
        chk("release_edges", edge_count, 32'd0);

        // Step latency
        SIGNAL_IN = 1; n = 0;
        while (sig_filt !== 1'b1 && n < 40) begin tick(); n++; end
        chk("latency", n, 10);
        chk("first_edge_count", edge_count, 32'd1);
        chk("first_div_pulse", 32'(sig_div), 32'd1);
        tick();
        chk("div_one_clk", 32'(sig_div), 32'd0);
        hold(1'b1, 10);
        hold(1'b0, 20);
        chk("falling_no_edge", edge_count, 32'd1);

        // Glitch rejection and saturation of the narrow counter
        hold(1'b1, 5);
        hold(1'b0, 15);
        chk("glitch_filt_low", 32'(sig_filt), 32'd0);
        chk("glitch_one", 32'(glitch_count), 32'd1);
        for (int i = 0; i < 20; i++) begin
            hold(1'b1, 5);
            hold(1'b0, 6);
        end
        chk("glitch_21", 32'(glitch_count), 32'd21);
        chk("glitch_sat", 32'(gc2), 32'd15);

        // Prescale 3 over 12 periods of 40 clocks
        prescale = 3; e0 = edge_count; ptimes.delete();
        periods(12, 20);
        chk("ps_pulses", ptimes.size(), 3);
        if (ptimes.size() == 3) begin
            chk("ps_gap1", ptimes[1] - ptimes[0], 160);
            chk("ps_gap2", ptimes[2] - ptimes[1], 160);
        end
        chk("ps_edges", edge_count - e0, 32'd12);

        // Prescale decrease mid-count
        prescale = 9; ptimes.delete();
        periods(5, 20);
        chk("pc_none_yet", ptimes.size(), 0);
        prescale = 2;
        periods(1, 20);
        chk("pc_next_edge", ptimes.size(), 1);
        ptimes.delete();
        periods(3, 20);
        chk("pc_restart", ptimes.size(), 1);

        // Enable low freezes outputs
        sv_filt = sig_filt; sv_edge = edge_count; sv_glitch = glitch_count;
        enable = 0;
        for (int i = 0; i < 50; i++) begin
            if (i % 3 == 0) SIGNAL_IN = ~SIGNAL_IN;
            tick();
        end
        hold(1'b0, 4);
        chk("frz_filt", 32'(sig_filt), 32'(sv_filt));
        chk("frz_edges", edge_count, sv_edge);
        chk("frz_glitch", 32'(glitch_count), 32'(sv_glitch));
        enable = 1;
        hold(1'b0, 12);

        // Invert toggle with a steady input
        invert = 1; n = 0;
        while (sig_filt !== 1'b1 && n < 40) begin tick(); n++; end
        chk("inv_rise", n, FL);
        invert = 0; n = 0;
        while (sig_filt !== 1'b0 && n < 40) begin tick(); n++; end
        chk("inv_fall", n, FL);

        // Disable clears the divider: a full prescale+1 edges are needed again
        enable = 0; hold(1'b0, 3); enable = 1; hold(1'b0, 3);
        ptimes.delete();
        periods(2, 20);
        chk("reen_no_pulse", ptimes.size(), 0);
        periods(1, 20);
        chk("reen_pulse", ptimes.size(), 1);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) invert = ~invert;
            if ($urandom_range(0, 31) == 0) enable = ~enable;
            if ($urandom_range(0, 39) == 0) prescale = 8'($urandom_range(0, 3));
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 25));
        end
        enable = 1; invert = 0;
        hold(1'b1, 30);

        // Asynchronous reset mid-operation
        @(negedge clk); #2;
        rst_n = 0;
        #1;
        chk("arst_filt", 32'(sig_filt), 32'd0);
        chk("arst_edges", edge_count, 32'd0);
        chk("arst_glitch", 32'(glitch_count), 32'd0);
        mreset();
        SIGNAL_IN = 0;
        tick();
        rst_n = 1;
        ptimes.delete();
        hold(1'b0, 15);
        chk("arst_no_pulse", ptimes.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
